// File: rtl/muntjac_trace_buffer.sv
// Instruction-trace ring buffer: records retired instructions, freezes a programmable
// number of entries after a PC trigger, then streams the window out oldest-first.
module muntjac_trace_buffer #(
  parameter int Depth      = 256,
  parameter int PcWidth    = 64,
  parameter int InstrWidth = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       trace_valid_i,
  input  logic [PcWidth-1:0]         trace_pc_i,
  input  logic [InstrWidth-1:0]      trace_instr_i,
  input  logic                       arm_i,
  input  logic                       trig_en_i,
  input  logic [PcWidth-1:0]         trig_pc_i,
  input  logic [$clog2(Depth):0]     post_count_i,
  input  logic                       drain_i,
  output logic [2:0]                 state_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PcWidth-1:0]         out_pc_o,
  output logic [InstrWidth-1:0]      out_instr_o,
  output logic                       out_last_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam int EW = PcWidth + InstrWidth;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECORD = 3'd1,
    POST   = 3'd2,
    DONE   = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  state_e                r_state;
  logic [EW-1:0]         r_mem [Depth];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_post_rem;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_issue_rem;
  logic [EW-1:0]         r_rd_data;
  logic                  r_rd_vld;
  logic                  r_out_valid;
  logic [PcWidth-1:0]    r_out_pc;
  logic [InstrWidth-1:0] r_out_instr;

  logic          w_wr_en;
  logic          w_trig;
  logic          w_xfer;
  logic          w_load_out;
  logic          w_issue;
  logic [AW-1:0] w_post_clamp;

  assign w_wr_en    = (r_state == RECORD || r_state == POST) && trace_valid_i && !arm_i;
  assign w_trig     = (r_state == RECORD) && trace_valid_i && trig_en_i && (trace_pc_i == trig_pc_i);
  assign w_xfer     = r_out_valid && out_ready_i;
  // The read register acts as a prefetch slot: it refills in the same cycle it hands
  // its entry to the output register, which sustains one transfer per cycle.
  assign w_load_out = r_rd_vld && (!r_out_valid || w_xfer);
  assign w_issue    = (r_state == DRAIN) && (r_issue_rem != '0) && (!r_rd_vld || w_load_out);
  assign w_post_clamp = (post_count_i > CW'(Depth - 1)) ? AW'(Depth - 1) : post_count_i[AW-1:0];

  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {trace_pc_i, trace_instr_i};
    if (w_issue) r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_rem  <= '0;
      r_count     <= '0;
      r_issue_rem <= '0;
      r_rd_vld    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
    end else if (arm_i) begin
      r_state     <= RECORD;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_issue_rem <= '0;
      r_rd_vld    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count != CW'(Depth)) r_count <= r_count + CW'(1);
      end
      case (r_state)
        RECORD: begin
          if (w_trig) begin
            if (post_count_i == '0) begin
              r_state <= DONE;
            end else begin
              r_post_rem <= w_post_clamp;
              r_state    <= POST;
            end
          end
        end
        POST: begin
          if (trace_valid_i) begin
            r_post_rem <= r_post_rem - AW'(1);
            if (r_post_rem == AW'(1)) r_state <= DONE;
          end
        end
        DONE: begin
          if (drain_i && r_count != '0) begin
            r_state     <= DRAIN;
            r_rd_ptr    <= r_wr_ptr - r_count[AW-1:0];
            r_issue_rem <= r_count;
          end
        end
        DRAIN: begin
          if (w_issue) begin
            r_rd_ptr    <= r_rd_ptr + AW'(1);
            r_issue_rem <= r_issue_rem - CW'(1);
          end
          if (w_issue)         r_rd_vld <= 1'b1;
          else if (w_load_out) r_rd_vld <= 1'b0;
          if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_rd_data[EW-1:InstrWidth];
            r_out_instr <= r_rd_data[InstrWidth-1:0];
          end else if (w_xfer) begin
            r_out_valid <= 1'b0;
          end
          if (w_xfer) begin
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_rd_vld    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o     = r_state;
  assign count_o     = r_count;
  assign out_valid_o = r_out_valid;
  assign out_pc_o    = r_out_pc;
  assign out_instr_o = r_out_instr;
  assign out_last_o  = r_out_valid && (r_count == CW'(1));
endmodule

// File: tb/tb_muntjac_trace_buffer.sv
// Scoreboard bench for muntjac_trace_buffer: a reference ring queue is filled as traces
// are driven and compared beat by beat against the drained stream.
module tb_muntjac_trace_buffer;
  localparam int Depth = 256;
  localparam int PW    = 64;
  localparam int IW    = 32;
  localparam int CW    = $clog2(Depth) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          trace_valid_i;
  logic [PW-1:0] trace_pc_i;
  logic [IW-1:0] trace_instr_i;
  logic          arm_i;
  logic          trig_en_i;
  logic [PW-1:0] trig_pc_i;
  logic [CW-1:0] post_count_i;
  logic          drain_i;
  logic [2:0]    state_o;
  logic [CW-1:0] count_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [PW-1:0] out_pc_o;
  logic [IW-1:0] out_instr_o;
  logic          out_last_o;

  muntjac_trace_buffer #(.Depth(Depth), .PcWidth(PW), .InstrWidth(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trace_valid_i(trace_valid_i), .trace_pc_i(trace_pc_i),
    .trace_instr_i(trace_instr_i), .arm_i(arm_i), .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i),
    .post_count_i(post_count_i), .drain_i(drain_i), .state_o(state_o), .count_o(count_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_instr_o(out_instr_o), .out_last_o(out_last_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PW+IW-1:0] exp_q[$];
  bit model_rec = 1'b0;

  task automatic check_eq(input string tag, input logic [PW+IW-1:0] got, input logic [PW+IW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] instr_of(input logic [PW-1:0] pc);
    return pc[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic send_trace(input logic [PW-1:0] pc);
    trace_valid_i = 1'b1;
    trace_pc_i    = pc;
    trace_instr_i = instr_of(pc);
    if (model_rec) begin
      exp_q.push_back({pc, instr_of(pc)});
      if (exp_q.size() > Depth) void'(exp_q.pop_front());
    end
    tick();
    trace_valid_i = 1'b0;
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain_run(input bit toggle, input int abort_after);
    int beats = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit done = 1'b0;
    logic [PW+IW-1:0] held = '0;
    logic [PW+IW-1:0] e;
    drain_i = 1'b1; tick(); drain_i = 1'b0;
    @(negedge clk_i);
    check_eq("early_valid", out_valid_o, 0);
    check_eq("drain_state", state_o, 4);
    while (!done) begin
      out_ready_i = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      @(negedge clk_i);
      if (out_valid_o) begin
        if (stalled) check_eq("stall_stable", {out_pc_o, out_instr_o}, held);
        if (out_ready_i) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            check_eq("extra_beat", 1, 0);
            done = 1'b1;
          end else begin
            e = exp_q.pop_front();
            check_eq("out_pc", out_pc_o, e[PW+IW-1:IW]);
            check_eq("out_instr", out_instr_o, e[IW-1:0]);
            check_eq("out_last", out_last_o, exp_q.size() == 0);
            beats++;
            if (exp_q.size() == 0 || beats == abort_after) done = 1'b1;
          end
        end else begin
          stalled = 1'b1;
          held = {out_pc_o, out_instr_o};
        end
      end else begin
        stalled = 1'b0;
      end
      cyc++;
      if (cyc > 2000) begin
        check_eq("drain_timeout", 1, 0);
        done = 1'b1;
      end
      tick();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic check_drained();
    @(negedge clk_i);
    check_eq("post_drain_valid", out_valid_o, 0);
    check_eq("post_drain_state", state_o, 0);
    check_eq("post_drain_count", count_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; trace_valid_i = 1'b0; trace_pc_i = '0; trace_instr_i = '0;
    arm_i = 1'b0; trig_en_i = 1'b0; trig_pc_i = '0; post_count_i = '0;
    drain_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_state", state_o, 0);
    check_eq("rst_count", count_o, 0);
    check_eq("rst_valid", out_valid_o, 0);
    check_eq("rst_last", out_last_o, 0);
    check_eq("rst_payload", {out_pc_o, out_instr_o}, 0);
    tick();

    // 1: ten traces, trigger on the tenth with no post window
    pulse_arm();
    check_eq("t1_armed", state_o, 1);
    trig_en_i = 1'b1; trig_pc_i = 64'h1024; post_count_i = '0;
    model_rec = 1'b1;
    for (int i = 0; i < 10; i++) send_trace(64'h1000 + 4 * i);
    model_rec = 1'b0;
    check_eq("t1_state", state_o, 3);
    check_eq("t1_count", count_o, 10);
    drain_run(1'b0, 0);
    check_drained();

    // 2: wraparound, count saturates at Depth
    pulse_arm();
    trig_pc_i = 64'h4AC;
    model_rec = 1'b1;
    for (int i = 0; i < 300; i++) send_trace(64'(i * 4));
    model_rec = 1'b0;
    check_eq("t2_state", state_o, 3);
    check_eq("t2_count", count_o, Depth);
    check_eq("t2_first_exp", exp_q[0][PW+IW-1:IW], 64'hB0);
    drain_run(1'b0, 0);
    check_drained();

    // 3: trigger on 5th trace with three post entries; 9th trace ignored
    pulse_arm();
    trig_pc_i = 64'h2010; post_count_i = CW'(3);
    model_rec = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_trace(64'h2000 + 4 * i);
      if (i == 4) check_eq("t3_post", state_o, 2);
    end
    model_rec = 1'b0;
    check_eq("t3_state", state_o, 3);
    check_eq("t3_count", count_o, 8);
    send_trace(64'h2020);
    check_eq("t3_ignored", count_o, 8);
    drain_run(1'b0, 0);
    check_drained();

    // 4: drain with ready toggling 1,0,0,1
    pulse_arm();
    trig_pc_i = 64'h3014; post_count_i = '0;
    model_rec = 1'b1;
    for (int i = 0; i < 6; i++) send_trace(64'h3000 + 4 * i);
    model_rec = 1'b0;
    check_eq("t4_count", count_o, 6);
    drain_run(1'b1, 0);
    check_drained();

    // post_count above Depth-1 clamps: trigger entry plus 255 more fills the ring
    pulse_arm();
    trig_pc_i = 64'h8000; post_count_i = CW'(511);
    send_trace(64'h8000);
    for (int i = 1; i < 255; i++) send_trace(64'h8000 + 4 * i);
    check_eq("clamp_still_post", state_o, 2);
    send_trace(64'h8000 + 4 * 255);
    check_eq("clamp_done", state_o, 3);
    check_eq("clamp_count", count_o, Depth);

    // 5: re-arm mid-drain after two beats
    pulse_arm();
    trig_pc_i = 64'h5010; post_count_i = '0;
    model_rec = 1'b1;
    for (int i = 0; i < 5; i++) send_trace(64'h5000 + 4 * i);
    model_rec = 1'b0;
    drain_run(1'b0, 2);
    arm_i = 1'b1; tick(); arm_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check_eq("t5_valid", out_valid_o, 0);
    check_eq("t5_state", state_o, 1);
    check_eq("t5_count", count_o, 0);
    tick();

    // 6: reset while in POST, later drain is ignored
    pulse_arm();
    trig_pc_i = 64'h6000; post_count_i = CW'(5);
    send_trace(64'h6000);
    send_trace(64'h6004);
    check_eq("t6_post", state_o, 2);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("t6_state", state_o, 0);
    check_eq("t6_count", count_o, 0);
    check_eq("t6_valid", out_valid_o, 0);
    tick();
    drain_i = 1'b1; out_ready_i = 1'b1; tick(); drain_i = 1'b0;
    repeat (3) tick();
    @(negedge clk_i);
    check_eq("t6_drain_ignored", state_o, 0);
    check_eq("t6_no_beat", out_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
